sd_dat_seq: RTL and testbench

Bit-level sequencer for the 4-bit SD card DAT bus in the DE2-115 web system. It transfers one data block in either direction, with per-line CRC16, the write CRC-status token and the busy wait. It replaces software bit-banging of the DAT PIO: it drives the same four tri-state lines through `dat_out`/`dat_oe` and samples `dat_in`. The SD clock generator supplies `sd_tick`; the DMA/host side moves bytes over simple strobes.

---
 rtl/sd_dat_pkg.sv | 42 ++++
 rtl/sd_crc16.sv | 37 +++
 rtl/sd_dat_seq.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_sd_dat_seq.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_dat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_dat_pkg
// Description : Shared types and constants for the SD DAT bus sequencer:
//               FSM state encoding, completion status codes and the CRC16
//               polynomial with a single-bit update helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_dat_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RD_WAIT  = 4'd1,
        RD_DATA  = 4'd2,
        RD_CRC   = 4'd3,
        RD_END   = 4'd4,
        WR_PRE   = 4'd5,
        WR_START = 4'd6,
        WR_DATA  = 4'd7,
        WR_CRC   = 4'd8,
        WR_END   = 4'd9,
        WR_TOK   = 4'd10,
        WR_BUSY  = 4'd11,
        FINISH   = 4'd12
    } state_t;

    localparam logic [2:0] ST_OK       = 3'd0;
    localparam logic [2:0] ST_CRC      = 3'd1;
    localparam logic [2:0] ST_TIMEOUT  = 3'd2;
    localparam logic [2:0] ST_UNDERRUN = 3'd3;
    localparam logic [2:0] ST_REJECT   = 3'd4;

    // x^16 + x^12 + x^5 + 1
    localparam logic [15:0] c_CRC16_POLY = 16'h1021;

    // One MSB-first step of the CRC16 shift register.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        return {crc[14:0], 1'b0} ^ ({16{crc[15] ^ din}} & c_CRC16_POLY);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_crc16.sv
`default_nettype none
// ============================================================================
// Module      : sd_crc16
// Description : Serial 1-bit CRC16 (x^16+x^12+x^5+1, init 0, MSB first).
// Ports       : clk      - system clock
//               rst      - synchronous active-high reset
//               i_clear  - synchronous clear to 0
//               i_enable - advance the register by one bit
//               i_bit    - input bit
//               o_crc    - current CRC register
// Revision    : 1.0 - initial release
// ============================================================================
module sd_crc16
    import sd_dat_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic        i_bit,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_crc <= '0;
        end else if (i_enable) begin
            r_crc <= crc16_step(r_crc, i_bit);
        end
    end

    assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/sd_dat_seq.sv
`default_nettype none
// ============================================================================
// Module      : sd_dat_seq
// Description : Bit-level sequencer for the 4-bit SD DAT bus. Moves one data
//               block in either direction with per-line CRC16, the write
//               CRC-status token and the busy wait. All DAT activity happens
//               on sd_tick cycles.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               sd_tick             - one-clk strobe per SD clock period
//               rd_start/wr_start   - start pulses (read wins when both)
//               rd_data/rd_valid    - received byte stream
//               wr_data/wr_valid/wr_ready - byte source into holding register
//               dat_in/dat_out/dat_oe     - DAT[3:0] tri-state pins
//               busy, done, status  - transfer progress and result
// Revision    : 1.0 - initial release
// ============================================================================
module sd_dat_seq
    import sd_dat_pkg::*;
#(
    parameter int BLOCK_BYTES   = 512,
    parameter int TIMEOUT_TICKS = 1048575
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sd_tick,
    input  logic       rd_start,
    input  logic       wr_start,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [3:0] dat_in,
    output logic [3:0] dat_out,
    output logic [3:0] dat_oe,
    output logic       busy,
    output logic       done,
    output logic [2:0] status
);

    localparam int                 c_NIB_W    = $clog2(2 * BLOCK_BYTES);
    localparam int                 c_TO_W     = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [c_NIB_W-1:0] c_NIB_LAST = c_NIB_W'(2 * BLOCK_BYTES - 1);
    localparam logic [c_TO_W-1:0]  c_TO_MAX   = c_TO_W'(TIMEOUT_TICKS);

    state_t              r_state;
    logic [c_NIB_W-1:0]  r_nib;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic [3:0]          r_bit_cnt;
    logic [2:0]          r_tok_cnt;
    logic [2:0]          r_tok;
    logic [3:0]          r_hi;
    logic [3:0]          r_lo;
    logic [7:0]          r_hold;
    logic                r_hold_full;

    logic [15:0] w_crc [4];
    logic [3:0]  w_crc_msb;
    logic [3:0]  w_crc_bit;
    logic        w_crc_en;
    logic        w_crc_clear;
    logic        w_crc_zero;
    logic        w_start_wr;
    logic        w_load;
    logic        w_consume;
    logic        w_underrun;
    logic        w_hold_full_nxt;
    logic        w_wr_phase_nxt;

    assign w_start_wr  = (r_state == IDLE) && wr_start && !rd_start;
    assign w_crc_clear = (r_state == IDLE) && (rd_start || wr_start);

    // Holding register handshake; a byte leaves at its high-nibble tick.
    assign w_load          = wr_valid && wr_ready;
    assign w_consume       = sd_tick && (r_state == WR_DATA) && !r_nib[0] && r_hold_full;
    assign w_underrun      = sd_tick && (r_state == WR_DATA) && !r_nib[0] && !r_hold_full;
    assign w_hold_full_nxt = w_load || (r_hold_full && !w_consume);

    // Read: received bits go through the CRC including the trailing CRC
    // field, so a clean block leaves every register at zero. Write: during
    // WR_CRC each register is fed its own MSB, which turns it into a plain
    // left shift that serialises the CRC onto the line.
    assign w_crc_en = sd_tick && ((r_state inside {RD_DATA, RD_CRC, WR_CRC}) ||
                                  ((r_state == WR_DATA) && (r_nib[0] || r_hold_full)));

    always_comb begin
        w_crc_bit = dat_in;
        case (r_state)
            WR_DATA: w_crc_bit = r_nib[0] ? r_lo : r_hold[7:4];
            WR_CRC:  w_crc_bit = w_crc_msb;
            default: ;
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_crc
        sd_crc16 u_crc (
            .clk      (clk),
            .rst      (reset),
            .i_clear  (w_crc_clear),
            .i_enable (w_crc_en),
            .i_bit    (w_crc_bit[g]),
            .o_crc    (w_crc[g])
        );
        assign w_crc_msb[g] = w_crc[g][15];
    end

    assign w_crc_zero = ((w_crc[0] | w_crc[1] | w_crc[2] | w_crc[3]) == 16'h0000);

    // Whether the next state is one that accepts write bytes.
    always_comb begin
        w_wr_phase_nxt = 1'b0;
        case (r_state)
            IDLE:             w_wr_phase_nxt = w_start_wr;
            WR_PRE, WR_START: w_wr_phase_nxt = 1'b1;
            WR_DATA:          w_wr_phase_nxt = !(w_underrun || (sd_tick && (r_nib == c_NIB_LAST)));
            default:          ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_load) begin
            r_hold      <= wr_data;
            r_hold_full <= 1'b1;
        end else if (w_consume) begin
            r_hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_nib     <= '0;
            r_to_cnt  <= '0;
            r_bit_cnt <= '0;
            r_tok_cnt <= '0;
            r_tok     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            wr_ready  <= 1'b0;
            dat_out   <= 4'hF;
            dat_oe    <= 4'h0;
            busy      <= 1'b0;
            done      <= 1'b0;
            status    <= ST_OK;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            wr_ready <= w_wr_phase_nxt && !w_hold_full_nxt;

            case (r_state)
                IDLE: begin
                    if (rd_start || wr_start) begin
                        busy      <= 1'b1;
                        status    <= ST_OK;
                        r_to_cnt  <= '0;
                        r_nib     <= '0;
                        r_bit_cnt <= '0;
                        r_tok_cnt <= '0;
                        r_state   <= rd_start ? RD_WAIT : WR_PRE;
                    end
                end

                RD_WAIT: if (sd_tick) begin
                    if (dat_in == 4'h0) begin
                        r_state  <= RD_DATA;
                        r_to_cnt <= '0;
                        r_nib    <= '0;
                    end else if (r_to_cnt == c_TO_MAX) begin
                        status   <= ST_TIMEOUT;
                        r_state  <= FINISH;
                        r_to_cnt <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                RD_DATA: if (sd_tick) begin
                    if (!r_nib[0]) begin
                        r_hi <= dat_in;
                    end else begin
                        rd_data  <= {r_hi, dat_in};
                        rd_valid <= 1'b1;
                    end
                    if (r_nib == c_NIB_LAST) begin
                        r_nib     <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= RD_CRC;
                    end else begin
                        r_nib <= r_nib + 1'b1;
                    end
                end

                RD_CRC: if (sd_tick) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 4'd15) begin
                        r_state <= RD_END;
                    end
                end

                RD_END: if (sd_tick) begin
                    if ((dat_in != 4'hF) || !w_crc_zero) begin
                        status <= ST_CRC;
                    end
                    r_state <= FINISH;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end

                WR_PRE: if (sd_tick) begin
                    dat_oe  <= 4'hF;
                    dat_out <= 4'hF;
                    r_state <= WR_START;
                end

                WR_START: if (sd_tick) begin
                    dat_out <= 4'h0;
                    r_nib   <= '0;
                    r_state <= WR_DATA;
                end

                WR_DATA: if (sd_tick) begin
                    if (!r_nib[0]) begin
                        if (!r_hold_full) begin
                            status  <= ST_UNDERRUN;
                            dat_oe  <= 4'h0;
                            dat_out <= 4'hF;
                            r_nib   <= '0;
                            r_state <= FINISH;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            dat_out <= r_hold[7:4];
                            r_lo    <= r_hold[3:0];
                            r_nib   <= r_nib + 1'b1;
                        end
                    end else begin
                        dat_out <= r_lo;
                        if (r_nib == c_NIB_LAST) begin
                            r_nib     <= '0;
                            r_bit_cnt <= '0;
                            r_state   <= WR_CRC;
                        end else begin
                            r_nib <= r_nib + 1'b1;
                        end
                    end
                end

                WR_CRC: if (sd_tick) begin
                    dat_out   <= w_crc_msb;
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 4'd15) begin
                        r_state <= WR_END;
                    end
                end

                WR_END: if (sd_tick) begin
                    dat_out   <= 4'hF;
                    r_tok_cnt <= '0;
                    r_to_cnt  <= '0;
                    r_state   <= WR_TOK;
                end

                // r_tok_cnt: 0 waiting for start bit, 1..3 token bits, 4 end bit.
                WR_TOK: if (sd_tick) begin
                    dat_oe <= 4'h0;
                    if (r_tok_cnt == 3'd0) begin
                        if (!dat_in[0]) begin
                            r_tok_cnt <= 3'd1;
                        end else if (r_to_cnt == c_TO_MAX) begin
                            status   <= ST_TIMEOUT;
                            r_state  <= FINISH;
                            r_to_cnt <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end else if (r_tok_cnt != 3'd4) begin
                        r_tok     <= {r_tok[1:0], dat_in[0]};
                        r_tok_cnt <= r_tok_cnt + 1'b1;
                    end else begin
                        r_to_cnt <= '0;
                        if ({r_tok, dat_in[0]} == 4'b0101) begin
                            r_state <= WR_BUSY;
                        end else begin
                            status  <= ST_REJECT;
                            r_state <= FINISH;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end

                WR_BUSY: if (sd_tick) begin
                    if (dat_in[0]) begin
                        r_state  <= FINISH;
                        r_to_cnt <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else if (r_to_cnt == c_TO_MAX) begin
                        status   <= ST_TIMEOUT;
                        r_state  <= FINISH;
                        r_to_cnt <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                FINISH: r_state <= IDLE;

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_dat_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_dat_seq
// Description : Self-checking bench for sd_dat_seq. Acts as the SD card on
//               the DAT lines and as the byte source/sink on the host side;
//               expected streams come from a bit-serial CRC16 model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_dat_seq;

    localparam int BB = 4;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       sd_tick;
    logic       rd_start;
    logic       wr_start;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] dat_in;
    logic [3:0] dat_out;
    logic [3:0] dat_oe;
    logic       busy;
    logic       done;
    logic [2:0] status;

    sd_dat_seq #(
        .BLOCK_BYTES   (BB),
        .TIMEOUT_TICKS (TO)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .sd_tick  (sd_tick),
        .rd_start (rd_start),
        .wr_start (wr_start),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .dat_in   (dat_in),
        .dat_out  (dat_out),
        .dat_oe   (dat_oe),
        .busy     (busy),
        .done     (done),
        .status   (status)
    );

    always #5 clk = ~clk;

    int         n_total = 0;
    int         n_bad   = 0;
    logic [7:0] blk [BB];
    logic [7:0] rx_q [$];
    int         done_cnt = 0;
    logic [2:0] done_status = '0;

    logic [7:0] feed_buf [BB];
    int         feed_n   = 0;
    int         feed_idx = 0;
    int         hold_idx = -1;

    always @(negedge clk) begin
        if (rd_valid === 1'b1) rx_q.push_back(rd_data);
        if (done === 1'b1) begin
            done_cnt++;
            done_status = status;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; returns 1 time unit after the falling edge with the byte
    // source updated from the handshake seen on the rising edge.
    task automatic step();
        bit hs;
        hs = (wr_valid === 1'b1) && (wr_ready === 1'b1);
        @(negedge clk);
        #1;
        if (hs) feed_idx++;
        wr_valid = (feed_idx < feed_n) && (feed_idx != hold_idx);
        wr_data  = (feed_idx < feed_n) ? feed_buf[feed_idx] : 8'h00;
    endtask

    task automatic tick(input logic [3:0] din);
        repeat ($urandom_range(0, 2)) step();
        dat_in  = din;
        sd_tick = 1'b1;
        step();
        sd_tick = 1'b0;
        dat_in  = 4'hF;
    endtask

    function automatic logic [3:0] nib_of(input int k);
        return (k % 2 == 0) ? blk[k / 2][7:4] : blk[k / 2][3:0];
    endfunction

    // Reference CRC16 of one DAT line over the block, textbook form.
    function automatic logic [15:0] line_crc(input int line);
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        for (int k = 0; k < 2 * BB; k++) begin
            fb = c[15] ^ nib_of(k)[line];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    function automatic logic [3:0] crc_nib(input int j);
        logic [3:0]  n;
        logic [15:0] c;
        for (int i = 0; i < 4; i++) begin
            c    = line_crc(i);
            n[i] = c[15 - j];
        end
        return n;
    endfunction

    task automatic run_read(input bit both, input int flip_line, input logic [3:0] end_nib);
        int         d0;
        int         exp_st;
        logic [3:0] n;
        rx_q.delete();
        d0       = done_cnt;
        rd_start = 1'b1;
        wr_start = both;
        step();
        rd_start = 1'b0;
        wr_start = 1'b0;
        check_val("rd_busy", busy, 1);
        repeat ($urandom_range(0, 4)) tick(4'hF);
        tick(4'h0);
        for (int k = 0; k < 2 * BB; k++) begin
            tick(nib_of(k));
            if (k == 0) check_val("rd_latency0", rx_q.size(), 0);
            if (k == 1) check_val("rd_latency1", rx_q.size(), 1);
        end
        check_val("rd_wr_ready", wr_ready, 0);
        for (int j = 0; j < 16; j++) begin
            n = crc_nib(j);
            if (flip_line >= 0 && j == 5) n[flip_line] = ~n[flip_line];
            tick(n);
        end
        tick(end_nib);
        exp_st = (flip_line >= 0 || end_nib != 4'hF) ? 1 : 0;
        check_val("rd_done", done_cnt - d0, 1);
        check_val("rd_status", done_status, exp_st);
        check_val("rd_count", rx_q.size(), BB);
        for (int i = 0; i < BB; i++) begin
            check_val("rd_byte", (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hxxxx_xxxx, blk[i]);
        end
        check_val("rd_busy_end", busy, 0);
        step();
        step();
    endtask

    task automatic run_read_timeout();
        int d0;
        int t;
        rx_q.delete();
        d0       = done_cnt;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        t = 0;
        while (done_cnt == d0 && t < 30) begin
            tick(4'hF);
            t++;
        end
        check_val("to_ticks", t, TO + 1);
        check_val("to_status", done_status, 2);
        check_val("to_no_rdvalid", rx_q.size(), 0);
        step();
        step();
    endtask

    task automatic run_write(input int hold, input logic [2:0] token, input int busy_ticks);
        logic [3:0] exp_q [$];
        logic [3:0] drv_q [$];
        bit         resp_q [$];
        bit         prev_oe;
        bit         b;
        int         d0;
        int         t;
        int         exp_st;

        exp_q.push_back(4'hF);
        exp_q.push_back(4'h0);
        for (int k = 0; k < 2 * BB; k++) begin
            if (hold >= 0 && k >= 2 * hold) break;
            exp_q.push_back(nib_of(k));
        end
        if (hold < 0) begin
            for (int j = 0; j < 16; j++) exp_q.push_back(crc_nib(j));
            exp_q.push_back(4'hF);
        end
        exp_st = (hold >= 0) ? 3 : ((token == 3'b010) ? 0 : 4);

        feed_buf = blk;
        feed_n   = BB;
        feed_idx = 0;
        hold_idx = hold;
        d0       = done_cnt;
        wr_start = 1'b1;
        step();
        wr_start = 1'b0;
        check_val("wr_busy", busy, 1);

        prev_oe = 1'b0;
        t       = 0;
        while (done_cnt == d0 && t < 200) begin
            b = 1'b1;
            if (resp_q.size() > 0) b = resp_q.pop_front();
            tick({3'b111, b});
            t++;
            if (dat_oe == 4'hF) drv_q.push_back(dat_out);
            if (prev_oe && dat_oe == 4'h0 && done_cnt == d0) begin
                resp_q.push_back(1'b1);
                resp_q.push_back(1'b0);
                resp_q.push_back(token[2]);
                resp_q.push_back(token[1]);
                resp_q.push_back(token[0]);
                resp_q.push_back(1'b1);
                for (int i = 0; i < busy_ticks; i++) resp_q.push_back(1'b0);
            end
            prev_oe = (dat_oe == 4'hF);
        end

        check_val("wr_done", done_cnt - d0, 1);
        check_val("wr_status", done_status, exp_st);
        check_val("wr_len", drv_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check_val("wr_nib", (i < drv_q.size()) ? 32'(drv_q[i]) : 32'hxxxx_xxxx, exp_q[i]);
        end
        check_val("wr_oe_end", dat_oe, 0);
        check_val("wr_ready_end", wr_ready, 0);
        check_val("wr_busy_end", busy, 0);
        feed_n   = 0;
        hold_idx = -1;
        step();
        step();
    endtask

    task automatic run_reset_mid_read();
        int d0;
        for (int i = 0; i < BB; i++) blk[i] = 8'($urandom);
        d0       = done_cnt;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        tick(4'h0);
        tick(nib_of(0));
        tick(nib_of(1));
        tick(nib_of(2));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("rst_mid_oe", dat_oe, 0);
        check_val("rst_mid_busy", busy, 0);
        check_val("rst_mid_out", dat_out, 4'hF);
        check_val("rst_mid_status", status, 0);
        repeat (12) tick(4'hF);
        check_val("rst_mid_nodone", done_cnt - d0, 0);
        step();
    endtask

    initial begin
        reset    = 1'b1;
        sd_tick  = 1'b0;
        rd_start = 1'b0;
        wr_start = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        dat_in   = 4'hF;
        repeat (3) step();
        reset = 1'b0;
        step();

        check_val("rst_oe", dat_oe, 0);
        check_val("rst_out", dat_out, 4'hF);
        check_val("rst_rd_valid", rd_valid, 0);
        check_val("rst_wr_ready", wr_ready, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_status", status, 0);
        check_val("rst_rd_data", rd_data, 0);

        blk = '{8'h00, 8'h11, 8'h22, 8'h33};
        run_read(1'b0, -1, 4'hF);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < BB; i++) blk[i] = 8'($urandom);
            run_read(1'b0, -1, 4'hF);
        end
        run_read(1'b0, 2, 4'hF);
        run_read(1'b0, -1, 4'hE);
        run_read_timeout();

        blk = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
        run_write(-1, 3'b010, 3);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < BB; i++) blk[i] = 8'($urandom);
            run_write(-1, 3'b010, $urandom_range(0, 5));
        end
        run_write(2, 3'b010, 0);
        run_write(-1, 3'b101, 0);

        run_reset_mid_read();
        for (int i = 0; i < BB; i++) blk[i] = 8'($urandom);
        run_read(1'b1, -1, 4'hF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
